// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifq_pkg
// Description : Shared definitions for the instruction fetch queue: FSM state
//               encoding, fetch PC increment and the word-alignment mask
//               applied to redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } ifq_state_t;

    localparam int PC_STEP = 4;

    // Wide enough for the largest supported WIDTH; users slice the low bits.
    localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Circular buffer holding {pc, instruction} entries for the
//               fetch queue. Head/tail pointers plus an occupancy counter.
//               The head entry is visible combinationally on head_data.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               clear          - synchronous flush (priority over push/pop)
//               push/push_data - write an entry at the tail
//               pop            - drop the head entry
//               head_data      - entry at the head
//               empty, count   - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_head];

    assign w_push = push && !w_full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage is never reset; only entries between head and tail are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= push_data;
        end
    end

    // The credit scheme upstream guarantees a full buffer never sees a push.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
        !(push && !clear && w_full));

endmodule : ifq_fifo
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch queue. Issues sequential fetch requests to
//               a fixed-latency instruction memory under a credit scheme,
//               tags each request with its PC, and buffers returned
//               instructions for an in-order valid/ready consumer. A redirect
//               flushes queued and in-flight data and restarts fetching.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               imem_addr/imem_en       - memory request
//               imem_rdata              - memory data, MEM_LAT cycles later
//               redirect/redirect_pc    - flush and new fetch address
//               out_valid/out_ready     - consumer handshake
//               out_instr/out_pc        - head instruction and its address
// Config      : IFQ_BYPASS_EN - when defined, data returning into an empty
//               queue is presented on the outputs in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter int               MEM_LAT  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_en,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Holds queue occupancy plus in-flight count plus one without overflow.
    localparam int UW = $clog2(DEPTH + MEM_LAT + 2);

    ifq_state_t       r_state;
    ifq_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic             r_tag_vld [MEM_LAT];
    logic [WIDTH-1:0] r_tag_pc  [MEM_LAT];

    logic             w_redir;
    logic             w_issue;
    logic             w_ret_vld;
    logic [WIDTH-1:0] w_ret_pc;
    logic [UW-1:0]    w_inflight;
    logic [UW-1:0]    w_used;
    logic [UW-1:0]    w_used_nxt;
    logic             w_credit;

    logic [2*WIDTH-1:0] w_head;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               w_push;
    logic               w_fifo_pop;
    logic               w_avail;
    logic [2*WIDTH-1:0] w_out_data;
    logic               w_fire;

    // Redirect is ignored during the single INIT cycle after reset.
    assign w_redir   = redirect && (r_state != ST_INIT);
    assign w_ret_vld = r_tag_vld[MEM_LAT-1];
    assign w_ret_pc  = r_tag_pc[MEM_LAT-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + UW'(r_tag_vld[i]);
        end
    end

    // A returning entry is still counted as in flight, never twice.
    assign w_used   = UW'(w_count) + w_inflight;
    assign w_credit = (w_used < UW'(DEPTH));

    // ------------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------------
`ifdef IFQ_BYPASS_EN
    assign w_avail    = !w_empty || w_ret_vld;
    assign w_out_data = w_empty ? {w_ret_pc, imem_rdata} : w_head;
    // A bypassed entry consumed this cycle never needs to be stored.
    assign w_push     = w_ret_vld && !(w_empty && w_fire);
    assign w_fifo_pop = w_fire && !w_empty;
`else
    assign w_avail    = !w_empty;
    assign w_out_data = w_head;
    assign w_push     = w_ret_vld;
    assign w_fifo_pop = w_fire;
`endif

    assign out_valid = w_avail && !redirect && !reset;
    assign w_fire    = out_valid && out_ready;
    assign out_pc    = out_valid ? w_out_data[2*WIDTH-1:WIDTH] : '0;
    assign out_instr = out_valid ? w_out_data[WIDTH-1:0]       : '0;

    assign imem_en   = w_issue && !reset;
    assign imem_addr = reset ? RESET_PC : r_pc;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_used_nxt  = w_used;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_FULL: begin
                w_issue    = (r_state == ST_RUN) && w_credit && !w_redir;
                w_used_nxt = w_used + UW'(w_issue) - UW'(w_fire);
                if (w_redir) begin
                    w_state_nxt = ST_RUN;
                end else if (w_used_nxt >= UW'(DEPTH)) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (w_redir) begin
                r_pc <= redirect_pc & ALIGN_MASK[WIDTH-1:0];
            end else if (imem_en) begin
                r_pc <= r_pc + WIDTH'(PC_STEP);
            end
        end
    end

    // ------------------------------------------------------------------------
    // In-flight tag pipeline: one stage per cycle of memory latency
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || w_redir) begin
            r_tag_vld[0] <= 1'b0;
        end else begin
            r_tag_vld[0] <= imem_en;
        end
        r_tag_pc[0] <= r_pc;
    end

    for (genvar i = 1; i < MEM_LAT; i++) begin : g_tag_stage
        always_ff @(posedge clk) begin
            if (reset || w_redir) begin
                r_tag_vld[i] <= 1'b0;
            end else begin
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
            r_tag_pc[i] <= r_tag_pc[i-1];
        end
    end

    ifq_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_redir),
        .push      (w_push),
        .push_data ({w_ret_pc, imem_rdata}),
        .pop       (w_fifo_pop),
        .head_data (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

endmodule : ifetch_queue
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. Two instances (memory
//               latency 1 and 3) each run directed sequences followed by
//               randomized ready/redirect/reset traffic. The expected stream
//               after any flush is simply the sequential word addresses from
//               the new start PC; a monitor compares every accepted output
//               against that queue and every issued address against a fetch
//               address model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input int lat, input string nm,
                         input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL L%0d %s: got %0h expected %0h", lat, nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int          LAT = (g == 0) ? 1 : 3;
        localparam logic [31:0] RPC = (g == 0) ? 32'h0 : 32'h0000_1000;

        logic        reset;
        logic        imem_en;
        logic        redirect;
        logic        out_valid;
        logic        out_ready;
        logic [31:0] imem_addr;
        logic [31:0] imem_rdata;
        logic [31:0] redirect_pc;
        logic [31:0] out_instr;
        logic [31:0] out_pc;

        logic [31:0] pipe_addr [LAT];
        logic        pipe_vld  [LAT];
        logic [31:0] exp_pc_q [$];
        logic [31:0] exp_fetch;
        int          used_model;
        int          pops;
        int          total_pops;
        logic        done = 1'b0;

        ifetch_queue #(
            .WIDTH    (32),
            .DEPTH    (DEPTH),
            .MEM_LAT  (LAT),
            .RESET_PC (RPC)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .imem_addr   (imem_addr),
            .imem_en     (imem_en),
            .imem_rdata  (imem_rdata),
            .redirect    (redirect),
            .redirect_pc (redirect_pc),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .out_instr   (out_instr),
            .out_pc      (out_pc)
        );

        // Fixed-latency memory: data for a request appears LAT cycles later.
        always @(posedge clk) begin
            pipe_vld[0]  <= imem_en;
            pipe_addr[0] <= imem_addr;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
        assign imem_rdata = pipe_vld[LAT-1] ? instr_of(pipe_addr[LAT-1]) : 32'hBADC_0DE5;

        // Restart the reference stream at pc.
        task automatic flush(input logic [31:0] pc);
            exp_pc_q.delete();
            for (int k = 0; k < 1024; k++) begin
                exp_pc_q.push_back(pc + 32'(4 * k));
            end
            exp_fetch  = pc;
            used_model = 0;
            pops       = 0;
        endtask

        // Monitor
        always @(negedge clk) begin
            logic [31:0] p;
            if (reset) begin
                check(LAT, "rst_out_valid", {63'd0, out_valid}, 64'd0);
                check(LAT, "rst_imem_en",   {63'd0, imem_en},   64'd0);
                check(LAT, "rst_imem_addr", {32'd0, imem_addr}, {32'd0, RPC});
                check(LAT, "rst_out_instr", {32'd0, out_instr}, 64'd0);
                check(LAT, "rst_out_pc",    {32'd0, out_pc},    64'd0);
            end else begin
                if (redirect) begin
                    check(LAT, "redir_out_valid", {63'd0, out_valid}, 64'd0);
                    check(LAT, "redir_imem_en",   {63'd0, imem_en},   64'd0);
                end
                if (imem_en) begin
                    check(LAT, "fetch_addr", {32'd0, imem_addr}, {32'd0, exp_fetch});
                    check(LAT, "credit", {63'd0, (used_model < DEPTH)}, 64'd1);
                    exp_fetch = exp_fetch + 32'd4;
                    used_model++;
                end
                if (out_valid && out_ready) begin
                    if (exp_pc_q.size() == 0) begin
                        check(LAT, "unexpected_output", 64'd1, 64'd0);
                    end else begin
                        p = exp_pc_q.pop_front();
                        check(LAT, "out_pc",    {32'd0, out_pc},    {32'd0, p});
                        check(LAT, "out_instr", {32'd0, out_instr}, {32'd0, instr_of(p)});
                    end
                    used_model--;
                    pops++;
                    total_pops++;
                end
            end
        end

        initial begin : stim
            int cnt;
            int since;
            logic prev_rst;
            logic [31:0] rpc;

            total_pops  = 0;
            reset       = 1'b1;
            redirect    = 1'b0;
            redirect_pc = '0;
            out_ready   = 1'b1;
            flush(RPC);
            repeat (3) step();

            // Startup: address sequence and first-output latency.
            reset = 1'b0;
            for (int c = 0; c <= LAT + 3; c++) begin
                @(negedge clk);
                if (c == 0) check(LAT, "init_no_req", {63'd0, imem_en}, 64'd0);
                if (c >= 1 && c <= 4) begin
                    check(LAT, "start_en",   {63'd0, imem_en}, 64'd1);
                    check(LAT, "start_addr", {32'd0, imem_addr}, {32'd0, RPC + 32'(4 * (c - 1))});
                end
                if (c < LAT + 2) begin
                    check(LAT, "early_valid", {63'd0, out_valid}, 64'd0);
                end else if (c == LAT + 2) begin
                    check(LAT, "first_valid", {63'd0, out_valid}, 64'd1);
                    check(LAT, "first_pc",    {32'd0, out_pc}, {32'd0, RPC});
                end
                step();
            end

            // Back-pressure: only DEPTH requests, then stall until a pop.
            reset = 1'b1;
            out_ready = 1'b0;
            flush(RPC);
            repeat (LAT) step();
            reset = 1'b0;
            cnt = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (imem_en) cnt++;
                if (c == 9) check(LAT, "full_no_req", {63'd0, imem_en}, 64'd0);
                step();
            end
            check(LAT, "full_req_count", 64'(cnt), 64'(DEPTH));
            out_ready = 1'b1;
            @(negedge clk);
            check(LAT, "pop_cycle_no_req", {63'd0, imem_en}, 64'd0);
            check(LAT, "pop_cycle_valid",  {63'd0, out_valid}, 64'd1);
            step();
            @(negedge clk);
            check(LAT, "resume_en",   {63'd0, imem_en}, 64'd1);
            check(LAT, "resume_addr", {32'd0, imem_addr}, {32'd0, RPC + 32'd16});

            // Redirect with requests in flight; low bits of target ignored.
            repeat (3) step();
            redirect    = 1'b1;
            redirect_pc = 32'h0000_0105;
            flush(32'h0000_0104);
            step();
            redirect = 1'b0;
            @(negedge clk);
            check(LAT, "redir_next_en",   {63'd0, imem_en}, 64'd1);
            check(LAT, "redir_next_addr", {32'd0, imem_addr}, 64'h104);
            repeat (12) step();
            check(LAT, "redir_pops", {63'd0, (pops >= 3)}, 64'd1);

            // Address wrap at the top of the address space.
            redirect    = 1'b1;
            redirect_pc = 32'hFFFF_FFFC;
            flush(32'hFFFF_FFFC);
            step();
            redirect = 1'b0;
            repeat (15) step();
            check(LAT, "wrap_pops", {63'd0, (pops >= 3)}, 64'd1);

            // Reset one cycle after a redirect.
            redirect    = 1'b1;
            redirect_pc = 32'h0000_0200;
            flush(32'h0000_0200);
            step();
            redirect = 1'b0;
            reset    = 1'b1;
            flush(RPC);
            for (int k = 0; k <= LAT; k++) begin
                if (k == LAT) reset = 1'b0;
                @(negedge clk);
                check(LAT, "rst_redir_addr",  {32'd0, imem_addr}, {32'd0, RPC});
                check(LAT, "rst_redir_valid", {63'd0, out_valid}, 64'd0);
                step();
            end

            // Randomized traffic.
            since    = 1;
            prev_rst = 1'b0;
            for (int cyc = 0; cyc < 700; cyc++) begin
                redirect = 1'b0;
                if (prev_rst) begin
                    reset    = 1'b0;
                    prev_rst = 1'b0;
                    since    = 0;
                end else if ($urandom_range(0, 249) == 0) begin
                    reset    = 1'b1;
                    prev_rst = 1'b1;
                    flush(RPC);
                end else if (since >= 1 && $urandom_range(0, 29) == 0) begin
                    rpc         = $urandom;
                    redirect    = 1'b1;
                    redirect_pc = rpc;
                    flush(rpc & 32'hFFFF_FFFC);
                end
                if (cyc < 80) out_ready = ((cyc % 2) == 1);
                else          out_ready = ($urandom_range(0, 3) != 0);
                since++;
                step();
            end
            reset     = 1'b0;
            redirect  = 1'b0;
            out_ready = 1'b1;
            repeat (20) step();
            check(LAT, "random_pops", {63'd0, (total_pops > 100)}, 64'd1);
            done = 1'b1;
        end
    end

    initial begin
        wait (g_cfg[0].done && g_cfg[1].done);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, limit 200000 time units");
        $fatal(1, "timeout");
    end

endmodule : tb_ifetch_queue
`default_nettype wire

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter WIDTH, default 32: instruction and address width in bits; allowed range 8 to 64.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, 2 to 16.
REQ-003 Parameter MEM_LAT, default 1: fixed instruction-memory read latency in cycles, 1 to 4.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 imem_addr  out  WIDTH  fetch address presented to instruction memory.
REQ-008 imem_en  out  1  read request strobe, one request per cycle when high.
REQ-009 imem_rdata  in  WIDTH  read data, valid exactly MEM_LAT cycles after its request.
REQ-010 redirect  in  1  branch/PC-write flush request.
REQ-011 redirect_pc  in  WIDTH  new fetch address; bits [1:0] ignored, treated as zero.
REQ-012 out_valid  out  1  out_instr/out_pc hold a valid entry.
REQ-013 out_ready  in  1  consumer accepts the entry when out_valid and out_ready are both high.
REQ-014 out_instr  out  WIDTH  instruction at queue head.
REQ-015 out_pc  out  WIDTH  byte address of out_instr.

Function
REQ-016 FSM states INIT, RUN, FULL; INIT is held for one cycle after reset, then the FSM moves to RUN.
REQ-017 In INIT, imem_en SHALL be 0.
REQ-018 Credits = DEPTH - (queue occupancy + in-flight requests); RUN issues a request (imem_en=1, imem_addr=fetch PC) every cycle credits > 0.
REQ-019 RUN moves to FULL when credits reach 0; FULL moves back to RUN in the cycle after a pop frees a credit; in FULL, imem_en=0.
REQ-020 Fetch PC advances by 4 per issued request, wrapping modulo 2^WIDTH with no error.
REQ-021 Each request is tagged with its PC in a MEM_LAT-deep valid/PC shift register; imem_rdata is written with its tag in the cycle it returns.
REQ-022 Latency: a request issued in cycle t into an empty queue yields out_valid in cycle t+MEM_LAT+1 (no bypass).
REQ-023 Entries leave in request order; a pop and a push in the same cycle SHALL both take effect, occupancy unchanged.
REQ-024 No push SHALL occur when the queue is full; the credit rule makes that impossible, and an assertion SHALL check it.
REQ-025 redirect high: out_valid is forced to 0 combinationally that cycle, and no pop occurs.
REQ-026 redirect high: the queue and all in-flight tags are cleared at the clock edge, and imem_en=0 that cycle.
REQ-027 redirect high: fetch PC loads redirect_pc, the FSM goes to RUN, and the first new request is issued the next cycle.
REQ-028 Data returning after a redirect for a request issued before it SHALL be discarded.
REQ-029 redirect is held off while in INIT; it takes effect normally from RUN or FULL.

Reset
REQ-030 On reset: state INIT, fetch PC=RESET_PC, queue empty, in-flight tags cleared.
REQ-031 Output values during and after reset: out_valid=0, imem_en=0, imem_addr=RESET_PC, out_instr=0, out_pc=0.
REQ-032 Reset asserted mid-operation SHALL override redirect and discard all queued and in-flight data.

Configuration
REQ-033 With macro IFQ_BYPASS_EN defined, returning data for an empty queue is presented on out_instr/out_pc with out_valid=1 in the same cycle, giving latency t+MEM_LAT.
REQ-034 Under IFQ_BYPASS_EN, bypassed data is not stored if out_ready=1 that cycle.
REQ-035 Without IFQ_BYPASS_EN, all data passes through the queue, with the latency of REQ-022.

Structure
REQ-036 Shared package ifq_pkg: FSM state enum, PC_STEP=4, and the ALIGN_MASK constant.
REQ-037 Circular buffer in sub-module ifq_fifo (parametrised WIDTH*2, DEPTH), with head/tail pointers and an occupancy counter.

Verification
REQ-038 Reset, DEPTH=4, MEM_LAT=1, out_ready=1 -> imem_addr 0,4,8,... from cycle 1; out_pc=0 with out_valid in cycle 3 (cycle 2 with bypass).
REQ-039 out_ready=0 for 10 cycles -> exactly 4 requests issued, FSM in FULL, imem_en=0 until the first pop.
REQ-040 Redirect to 0x105 with 2 requests in flight -> next imem_addr=0x104; no stale instruction ever appears on out_instr.
REQ-041 Redirect to 0xFFFFFFFC -> out_pc sequence 0xFFFFFFFC, 0x0, 0x4.
REQ-042 MEM_LAT=3 with alternating out_ready -> output order matches request order, with no loss or duplication against a scoreboard.
REQ-043 Reset asserted one cycle after redirect -> imem_addr=RESET_PC and out_valid=0 for at least MEM_LAT+1 cycles.
